// File: rtl/soc_bram_dma_pkg.sv
// Shared SoC definitions for the BRAM DMA engine: FSM encoding and
// byte-lane write-mask constants (mask is active-low).
package soc_bram_dma_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR,
        FILL,
        FIN
    } dma_state_t;

    localparam logic [3:0] WMSK_ALL  = 4'h0;
    localparam logic [3:0] WMSK_NONE = 4'hF;

endpackage

// File: rtl/soc_bram_dma.sv
// Single-port BRAM DMA engine: forward word copy (alternating RD/WR cycles)
// or pattern fill (one write per cycle), with a one-cycle done pulse.
module soc_bram_dma
    import soc_bram_dma_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_fill,
    input  logic [AW-1:0] cmd_src,
    input  logic [AW-1:0] cmd_dst,
    input  logic [AW:0]   cmd_len,
    input  logic [31:0]   cmd_pattern,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] bram_addr,
    input  logic [31:0]   bram_rdata,
    output logic [31:0]   bram_wdata,
    output logic [3:0]    bram_wmsk,
    output logic          bram_we
);

    localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};

    dma_state_t    state;
    dma_state_t    next_state;
    logic [AW-1:0] src_ptr;
    logic [AW-1:0] dst_ptr;
    logic [AW:0]   count;
    logic [31:0]   pattern;
    logic          accept;
    logic          last;

    assign accept = (state == IDLE) && cmd_valid;
    // count holds words still to write, including the one being written now
    assign last   = (count == CNT_ONE);

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (cmd_len == '0) begin
                        next_state = FIN;
                    end else if (cmd_fill) begin
                        next_state = FILL;
                    end else begin
                        next_state = RD;
                    end
                end
            end
            RD:      next_state = WR;
            WR:      next_state = last ? FIN : RD;
            FILL:    next_state = last ? FIN : FILL;
            FIN:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            src_ptr <= '0;
            dst_ptr <= '0;
            count   <= '0;
            pattern <= '0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (accept) begin
                        src_ptr <= cmd_src;
                        dst_ptr <= cmd_dst;
                        count   <= cmd_len;
                        pattern <= cmd_pattern;
                    end
                end
                RD: src_ptr <= src_ptr + PTR_ONE;
                WR, FILL: begin
                    dst_ptr <= dst_ptr + PTR_ONE;
                    count   <= count - CNT_ONE;
                end
                default: ;
            endcase
        end
    end

    // Outputs decode registered state only, so reset forces them without a clock
    always_comb begin
        cmd_ready  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        bram_addr  = '0;
        bram_we    = 1'b0;
        bram_wmsk  = WMSK_NONE;
        bram_wdata = '0;
        case (state)
            IDLE: cmd_ready = 1'b1;
            RD: begin
                busy      = 1'b1;
                bram_addr = src_ptr;
            end
            WR: begin
                busy       = 1'b1;
                bram_addr  = dst_ptr;
                bram_we    = 1'b1;
                bram_wmsk  = WMSK_ALL;
                bram_wdata = bram_rdata;
            end
            FILL: begin
                busy       = 1'b1;
                bram_addr  = dst_ptr;
                bram_we    = 1'b1;
                bram_wmsk  = WMSK_ALL;
                bram_wdata = pattern;
            end
            FIN: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_soc_bram_dma.sv
// Self-checking bench for soc_bram_dma: BRAM model, write scoreboard and
// directed fill/copy/length/wrap/reset/busy scenarios.
module tb_soc_bram_dma;
    import soc_bram_dma_pkg::*;

    localparam int AW    = 8;
    localparam int DEPTH = 256;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_fill;
    logic [AW-1:0] cmd_src;
    logic [AW-1:0] cmd_dst;
    logic [AW:0]   cmd_len;
    logic [31:0]   cmd_pattern;
    logic          busy;
    logic          done;
    logic [AW-1:0] bram_addr;
    logic [31:0]   bram_rdata;
    logic [31:0]   bram_wdata;
    logic [3:0]    bram_wmsk;
    logic          bram_we;

    logic [31:0] mem      [DEPTH];
    logic [31:0] modelMem [DEPTH];
    wr_t         expQ[$];
    int          assertCount = 0;
    int          failCount   = 0;
    int          doneCount   = 0;
    int          expDone     = 0;
    int          doneSnap;

    soc_bram_dma #(.AW(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_fill    (cmd_fill),
        .cmd_src     (cmd_src),
        .cmd_dst     (cmd_dst),
        .cmd_len     (cmd_len),
        .cmd_pattern (cmd_pattern),
        .busy        (busy),
        .done        (done),
        .bram_addr   (bram_addr),
        .bram_rdata  (bram_rdata),
        .bram_wdata  (bram_wdata),
        .bram_wmsk   (bram_wmsk),
        .bram_we     (bram_we)
    );

    always #5 clk = ~clk;

    // Synchronous BRAM: registered read, byte-lane writes with active-low mask
    always @(posedge clk) begin
        bram_rdata <= mem[bram_addr];
        if (bram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (!bram_wmsk[b]) mem[bram_addr][8*b +: 8] <= bram_wdata[8*b +: 8];
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every observed write must match the next expected write in order
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) doneCount++;
        if (bram_we === 1'b1) begin
            if (expQ.size() == 0) begin
                assertCount++;
                failCount++;
                $error("[TB] FAIL unexpected write: observed addr %0h data %0h expected no write",
                       bram_addr, bram_wdata);
            end else begin
                wr_t e;
                e = expQ.pop_front();
                checkOutput("write addr", 32'(bram_addr), 32'(e.addr));
                checkOutput("write data", bram_wdata, e.data);
                checkOutput("write wmsk", 32'(bram_wmsk), 32'(WMSK_ALL));
            end
        end
    end

    task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
        mem[a]      <= d;
        modelMem[a]  = d;
    endtask

    task automatic pushFill(input logic [AW-1:0] dst, input logic [AW:0] len, input logic [31:0] pat);
        for (int i = 0; i < int'(len); i++) begin
            logic [AW-1:0] a;
            a = dst + AW'(i);
            modelMem[a] = pat;
            expQ.push_back('{addr: a, data: pat});
        end
    endtask

    task automatic pushCopy(input logic [AW-1:0] src, input logic [AW-1:0] dst, input logic [AW:0] len);
        for (int i = 0; i < int'(len); i++) begin
            logic [AW-1:0] s;
            logic [AW-1:0] d;
            s = src + AW'(i);
            d = dst + AW'(i);
            modelMem[d] = modelMem[s];
            expQ.push_back('{addr: d, data: modelMem[s]});
        end
    endtask

    // Drives one command for exactly one accepting edge; with hold, keeps a
    // different command asserted afterwards to probe the busy-ignore path.
    task automatic applyStimulus(input bit fill, input logic [AW-1:0] src, input logic [AW-1:0] dst,
                                 input logic [AW:0] len, input logic [31:0] pat, input bit hold);
        @(posedge clk); #1;
        cmd_valid   = 1'b1;
        cmd_fill    = fill;
        cmd_src     = src;
        cmd_dst     = dst;
        cmd_len     = len;
        cmd_pattern = pat;
        @(posedge clk); #1;
        if (hold) begin
            cmd_fill    = ~fill;
            cmd_src     = 8'h33;
            cmd_dst     = 8'h00;
            cmd_len     = 9'd2;
            cmd_pattern = 32'hBAD0_BAD0;
        end else begin
            cmd_valid = 1'b0;
        end
    endtask

    task automatic waitDone(input bit fill, input logic [AW-1:0] src, input int len,
                            input int expectDone, input string tag, input bit hold);
        int cyc;
        int access;
        access = fill ? len : 2 * len;
        for (cyc = 1; cyc <= expectDone + 8; cyc++) begin
            @(negedge clk);
            if (hold) checkOutput("ready low while busy", 32'(cmd_ready), 32'd0);
            if (done === 1'b1) break;
            if (cyc <= access) begin
                checkOutput("busy during access", 32'(busy), 32'd1);
                if (fill || (cyc % 2 == 0)) begin
                    checkOutput("we in write cycle", 32'(bram_we), 32'd1);
                end else begin
                    checkOutput("we in read cycle", 32'(bram_we), 32'd0);
                    checkOutput("read wmsk", 32'(bram_wmsk), 32'(WMSK_NONE));
                    checkOutput("read addr", 32'(bram_addr), 32'(src + AW'((cyc - 1) / 2)));
                end
            end
        end
        checkOutput(tag, 32'(cyc), 32'(expectDone));
        if (hold) cmd_valid = 1'b0;
        checkOutput("busy in FIN", 32'(busy), 32'd1);
        @(negedge clk);
        checkOutput("done single cycle", 32'(done), 32'd0);
        checkOutput("ready after done", 32'(cmd_ready), 32'd1);
        checkOutput("idle not busy", 32'(busy), 32'd0);
        checkOutput("write queue drained", 32'(expQ.size()), 32'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_fill    = 1'b0;
        cmd_src     = '0;
        cmd_dst     = '0;
        cmd_len     = '0;
        cmd_pattern = '0;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]      <= '0;
            modelMem[i]  = '0;
        end

        #12;
        checkOutput("reset cmd_ready", 32'(cmd_ready), 32'd1);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset we", 32'(bram_we), 32'd0);
        checkOutput("reset wmsk", 32'(bram_wmsk), 32'hF);
        checkOutput("reset addr", 32'(bram_addr), 32'd0);
        checkOutput("reset wdata", bram_wdata, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        $display("[TB] fill dst=0x10 len=4");
        pushFill(8'h10, 9'd4, 32'hDEAD_BEEF);
        applyStimulus(1'b1, 8'h00, 8'h10, 9'd4, 32'hDEAD_BEEF, 1'b0);
        waitDone(1'b1, 8'h00, 4, 5, "fill4 done cycle", 1'b0);
        expDone++;
        for (int i = 0; i < 4; i++) checkOutput("fill4 mem", mem[8'h10 + i], 32'hDEAD_BEEF);

        $display("[TB] copy src=0x00 dst=0x80 len=3");
        preload(8'h00, 32'h1111_1111);
        preload(8'h01, 32'h2222_2222);
        preload(8'h02, 32'h3333_3333);
        pushCopy(8'h00, 8'h80, 9'd3);
        applyStimulus(1'b0, 8'h00, 8'h80, 9'd3, 32'h0, 1'b0);
        waitDone(1'b0, 8'h00, 3, 7, "copy3 done cycle", 1'b0);
        expDone++;
        checkOutput("copy3 mem80", mem[8'h80], 32'h1111_1111);
        checkOutput("copy3 mem81", mem[8'h81], 32'h2222_2222);
        checkOutput("copy3 mem82", mem[8'h82], 32'h3333_3333);

        $display("[TB] zero-length fill and copy");
        applyStimulus(1'b1, 8'h00, 8'h50, 9'd0, 32'hFFFF_FFFF, 1'b0);
        waitDone(1'b1, 8'h00, 0, 1, "fill0 done cycle", 1'b0);
        expDone++;
        applyStimulus(1'b0, 8'h00, 8'h50, 9'd0, 32'h0, 1'b0);
        waitDone(1'b0, 8'h00, 0, 1, "copy0 done cycle", 1'b0);
        expDone++;

        $display("[TB] fill wrapping dst=0xFE len=4");
        pushFill(8'hFE, 9'd4, 32'h0BAD_F00D);
        applyStimulus(1'b1, 8'h00, 8'hFE, 9'd4, 32'h0BAD_F00D, 1'b0);
        waitDone(1'b1, 8'h00, 4, 5, "wrap done cycle", 1'b0);
        expDone++;
        checkOutput("wrap memFE", mem[8'hFE], 32'h0BAD_F00D);
        checkOutput("wrap memFF", mem[8'hFF], 32'h0BAD_F00D);
        checkOutput("wrap mem00", mem[8'h00], 32'h0BAD_F00D);
        checkOutput("wrap mem01", mem[8'h01], 32'h0BAD_F00D);

        $display("[TB] overlapping forward copy 0x20 -> 0x21");
        preload(8'h20, 32'hAAAA_0001);
        preload(8'h21, 32'hAAAA_0002);
        preload(8'h22, 32'hAAAA_0003);
        preload(8'h23, 32'hAAAA_0004);
        pushCopy(8'h20, 8'h21, 9'd3);
        applyStimulus(1'b0, 8'h20, 8'h21, 9'd3, 32'h0, 1'b0);
        waitDone(1'b0, 8'h20, 3, 7, "overlap done cycle", 1'b0);
        expDone++;
        for (int i = 1; i < 4; i++) checkOutput("overlap mem", mem[8'h20 + i], 32'hAAAA_0001);

        $display("[TB] command held while busy");
        preload(8'h00, 32'h7000_0000);
        preload(8'h01, 32'h7000_0001);
        preload(8'h02, 32'h7000_0002);
        pushCopy(8'h00, 8'h90, 9'd3);
        applyStimulus(1'b0, 8'h00, 8'h90, 9'd3, 32'h0, 1'b1);
        waitDone(1'b0, 8'h00, 3, 7, "busy copy done cycle", 1'b1);
        expDone++;
        for (int i = 0; i < 3; i++) checkOutput("busy copy mem", mem[8'h90 + i], 32'h7000_0000 + i);
        checkOutput("ignored cmd no fill", mem[8'h00], 32'h7000_0000);

        $display("[TB] reset during second WR of len=5 copy");
        for (int i = 0; i < 5; i++) begin
            preload(8'(i), 32'h5000_0000 + i);
            preload(8'hA0 + 8'(i), 32'hEEEE_EEEE);
        end
        expQ.push_back('{addr: 8'hA0, data: 32'h5000_0000});
        expQ.push_back('{addr: 8'hA1, data: 32'h5000_0001});
        applyStimulus(1'b0, 8'h00, 8'hA0, 9'd5, 32'h0, 1'b0);
        repeat (4) @(negedge clk);
        checkOutput("second WR active", 32'(bram_we), 32'd1);
        doneSnap = doneCount;
        #1 rst_n = 1'b0;
        #1;
        checkOutput("async reset we", 32'(bram_we), 32'd0);
        checkOutput("async reset busy", 32'(busy), 32'd0);
        checkOutput("async reset done", 32'(done), 32'd0);
        checkOutput("async reset ready", 32'(cmd_ready), 32'd1);
        checkOutput("async reset addr", 32'(bram_addr), 32'd0);
        checkOutput("async reset wmsk", 32'(bram_wmsk), 32'hF);
        checkOutput("async reset wdata", bram_wdata, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("no done after abort", 32'(doneCount), 32'(doneSnap));
        checkOutput("abort memA0 written", mem[8'hA0], 32'h5000_0000);
        for (int i = 2; i < 5; i++) checkOutput("abort dst untouched", mem[8'hA0 + i], 32'hEEEE_EEEE);
        checkOutput("abort queue drained", 32'(expQ.size()), 32'd0);

        $display("[TB] command on first edge after reset release");
        rst_n     = 1'b1;
        cmd_valid = 1'b1;
        cmd_fill  = 1'b0;
        cmd_len   = 9'd0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        waitDone(1'b0, 8'h00, 0, 1, "post-reset done cycle", 1'b0);
        expDone++;

        $display("[TB] full-length fill dst=0x40 len=256");
        pushFill(8'h40, 9'h100, 32'h600D_CAFE);
        applyStimulus(1'b1, 8'h00, 8'h40, 9'h100, 32'h600D_CAFE, 1'b0);
        waitDone(1'b1, 8'h00, 256, 257, "full fill done cycle", 1'b0);
        expDone++;
        checkOutput("full fill mem3F", mem[8'h3F], 32'h600D_CAFE);
        checkOutput("full fill mem40", mem[8'h40], 32'h600D_CAFE);
        checkOutput("full fill memFF", mem[8'hFF], 32'h600D_CAFE);
        checkOutput("full fill mem00", mem[8'h00], 32'h600D_CAFE);

        checkOutput("done pulse count", 32'(doneCount), 32'(expDone));
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
